dpram_rr_arbiter: RTL and testbench

- Shares the two ports of one dual-port RAM (1-cycle registered read, write-through on write) among NUM_REQ requesters.
- Grants up to two requesters per cycle: port 1 gets the first pending requester in round-robin order, port 2 gets the next.
- Tracks the one-cycle read latency and returns read data with a per-requester valid strobe.
- Sits between compute engines and the shared scratch RAM.

---
 rtl/dpram_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_dpram_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_rr_arbiter.sv
// Round-robin sharing of one dual-port RAM among NUM_REQ requesters; grant is same-cycle, read data
// returns one cycle after grant; a requester that is not granted simply holds req (no queuing inside).
module dpram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rdata,
    output logic                             ram_we1,
    output logic                             ram_we2,
    output logic [ADDR_WIDTH-1:0]            ram_addr1,
    output logic [ADDR_WIDTH-1:0]            ram_addr2,
    output logic [DATA_WIDTH-1:0]            ram_data1,
    output logic [DATA_WIDTH-1:0]            ram_data2,
    input  logic [DATA_WIDTH-1:0]            ram_out1,
    input  logic [DATA_WIDTH-1:0]            ram_out2
);

    localparam int ID_W = $clog2(NUM_REQ);

    function automatic logic [ID_W-1:0] wrap_id(input int v);
        int w;
        w = v;
        if (w >= NUM_REQ) begin
            w = w - NUM_REQ;
        end
        return w[ID_W-1:0];
    endfunction

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  p1_busy_q, p1_busy_d;
    logic                  p2_busy_q, p2_busy_d;
    logic [ID_W-1:0]       p1_tag_q, p1_tag_d;
    logic [ID_W-1:0]       p2_tag_q, p2_tag_d;
    logic                  p1_rd_q, p1_rd_d;
    logic                  p2_rd_q, p2_rd_d;

    logic                  a_found, b_found;
    logic [ID_W-1:0]       a_id, b_id, scan_id;
    logic                  a_we, b_we;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_data, b_data;
    logic                  b_ok;
    logic                  grant_a, grant_b;

    // First two pending requesters starting at the pointer.
    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_id    = '0;
        b_id    = '0;
        scan_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_id = wrap_id(int'(ptr_q) + i);
            if (req[scan_id]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_id    = scan_id;
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_id    = scan_id;
                end
            end
        end
    end

    always_comb begin
        a_we   = req_we[a_id];
        b_we   = req_we[b_id];
        a_addr = req_addr[int'(a_id)*ADDR_WIDTH +: ADDR_WIDTH];
        b_addr = req_addr[int'(b_id)*ADDR_WIDTH +: ADDR_WIDTH];
        a_data = req_data[int'(a_id)*DATA_WIDTH +: DATA_WIDTH];
        b_data = req_data[int'(b_id)*DATA_WIDTH +: DATA_WIDTH];
        // Same-address pairs are only safe when neither side writes.
        b_ok    = b_found && ((a_addr != b_addr) || (!a_we && !b_we));
        grant_a = a_found && !reset;
        grant_b = b_ok && !reset;
    end

    always_comb begin
        gnt = '0;
        if (grant_a) begin
            gnt[a_id] = 1'b1;
        end
        if (grant_b) begin
            gnt[b_id] = 1'b1;
        end
        ram_we1   = grant_a && a_we;
        ram_addr1 = a_found ? a_addr : '0;
        ram_data1 = a_found ? a_data : '0;
        ram_we2   = grant_b && b_we;
        ram_addr2 = b_ok ? b_addr : '0;
        ram_data2 = b_ok ? b_data : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_b) begin
            ptr_d = wrap_id(int'(b_id) + 1);
        end else if (grant_a) begin
            ptr_d = wrap_id(int'(a_id) + 1);
        end
        p1_busy_d = grant_a;
        p1_tag_d  = a_id;
        p1_rd_d   = grant_a && !a_we;
        p2_busy_d = grant_b;
        p2_tag_d  = b_id;
        p2_rd_d   = grant_b && !b_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            p1_busy_q <= 1'b0;
            p1_tag_q  <= '0;
            p1_rd_q   <= 1'b0;
            p2_busy_q <= 1'b0;
            p2_tag_q  <= '0;
            p2_rd_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            p1_busy_q <= p1_busy_d;
            p1_tag_q  <= p1_tag_d;
            p1_rd_q   <= p1_rd_d;
            p2_busy_q <= p2_busy_d;
            p2_tag_q  <= p2_tag_d;
            p2_rd_q   <= p2_rd_d;
        end
    end

    // Read return is masked while reset is held so a stale in-flight read never leaks out.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (!reset) begin
            if (p1_busy_q && p1_rd_q) begin
                rvalid[p1_tag_q] = 1'b1;
                rdata[int'(p1_tag_q)*DATA_WIDTH +: DATA_WIDTH] = ram_out1;
            end
            if (p2_busy_q && p2_rd_q) begin
                rvalid[p2_tag_q] = 1'b1;
                rdata[int'(p2_tag_q)*DATA_WIDTH +: DATA_WIDTH] = ram_out2;
            end
        end
    end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed bench for dpram_rr_arbiter with a behavioural dual-port RAM and a read-return scoreboard.
module tb_dpram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req, req_we, gnt, rvalid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data, rdata;
    logic              ram_we1, ram_we2;
    logic [AW-1:0]     ram_addr1, ram_addr2;
    logic [DW-1:0]     ram_data1, ram_data2, ram_out1, ram_out2;

    dpram_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_we1(ram_we1), .ram_we2(ram_we2), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
        .ram_data1(ram_data1), .ram_data2(ram_data2), .ram_out1(ram_out1), .ram_out2(ram_out2)
    );

    // Dual-port RAM: registered read, write-through; preloaded with addr ^ 0xFF.
    logic          init_mem;
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= DW'(k) ^ 8'hFF;
            ram_out1 <= '0;
            ram_out2 <= '0;
        end else begin
            if (ram_we1) mem[ram_addr1] <= ram_data1;
            if (ram_we2) mem[ram_addr2] <= ram_data2;
            ram_out1 <= ram_we1 ? ram_data1 : mem[ram_addr1];
            ram_out2 <= ram_we2 ? ram_data2 : mem[ram_addr2];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        req      = '0;
        req_we   = '0;
        req_addr = '0;
        req_data = '0;
    endtask

    task automatic set_rq(input int id, input bit w, input logic [7:0] a, input logic [7:0] d);
        req[id]              = 1'b1;
        req_we[id]           = w;
        req_addr[id*AW +: AW] = a;
        req_data[id*DW +: DW] = d;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: sample after the active edge, pop one expectation per asserted rvalid bit.
    always begin
        @(posedge clk);
        #2;
        if (reset) chk("rvalid_in_reset", rvalid, 0);
        for (int i = 0; i < N; i++) begin
            if (rvalid[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rvalid: got rvalid[%0d]=1 expected 0 (cycle %0d)", i, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rv_id", i, mon_e.id);
                    chk("rv_data", rdata[i*DW +: DW], mon_e.data);
                    chk("rv_cycle", cyc, mon_e.cyc);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rvalid: got none expected id %0d data %0h at cycle %0d", mon_e.id, mon_e.data, mon_e.cyc);
        end
    end

    initial begin
        reset    = 1'b1;
        init_mem = 1'b1;
        clr();
        repeat (3) @(negedge clk);
        // Requests present while reset is held must not be granted.
        set_rq(0, 1'b1, 8'h01, 8'h5A);
        #1;
        chk("gnt_in_reset", gnt, 0);
        chk("we1_in_reset", ram_we1, 0);
        @(negedge clk);
        init_mem = 1'b0;
        reset    = 1'b0;
        clr();

        for (int c = 0; c < 5; c++) begin
            #1;
            chk("idle_gnt", gnt, 0);
            chk("idle_we1", ram_we1, 0);
            chk("idle_we2", ram_we2, 0);
            chk("idle_rvalid", rvalid, 0);
            @(negedge clk);
        end

        // Rotation from ptr=0 with everyone reading.
        for (int c = 0; c < 4; c++) begin
            logic [3:0] eg;
            clr();
            for (int i = 0; i < N; i++) set_rq(i, 1'b0, 8'h30 + 8'(i), 8'h00);
            eg = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            #1;
            chk("rot_gnt", gnt, eg);
            for (int i = 0; i < N; i++) if (eg[i]) push(i, (8'h30 + 8'(i)) ^ 8'hFF);
            @(negedge clk);
        end
        clr();

        // Single write then read back.
        do_reset();
        clr();
        set_rq(0, 1'b1, 8'h10, 8'hA5);
        #1;
        chk("wr_gnt", gnt, 4'b0001);
        chk("wr_we1", ram_we1, 1);
        chk("wr_addr1", ram_addr1, 8'h10);
        chk("wr_data1", ram_data1, 8'hA5);
        chk("wr_we2", ram_we2, 0);
        @(negedge clk);
        clr();
        set_rq(0, 1'b0, 8'h10, 8'h00);
        #1;
        chk("rd_gnt", gnt, 4'b0001);
        chk("rd_we1", ram_we1, 0);
        push(0, 8'hA5);
        @(negedge clk);
        clr();

        // Dual grant, then confirm pointer moved to 3.
        do_reset();
        clr();
        set_rq(1, 1'b0, 8'h03, 8'h00);
        set_rq(2, 1'b0, 8'h04, 8'h00);
        #1;
        chk("dual_gnt", gnt, 4'b0110);
        chk("dual_addr1", ram_addr1, 8'h03);
        chk("dual_addr2", ram_addr2, 8'h04);
        chk("dual_we2", ram_we2, 0);
        push(1, 8'hFC);
        push(2, 8'hFB);
        @(negedge clk);
        clr();
        for (int i = 0; i < N; i++) set_rq(i, 1'b0, 8'h30 + 8'(i), 8'h00);
        #1;
        chk("ptr3_gnt", gnt, 4'b1001);
        push(0, 8'hCF);
        push(3, 8'hCC);
        @(negedge clk);
        clr();

        // Address conflict: write wins port 1, reader waits and sees the new value.
        do_reset();
        clr();
        set_rq(0, 1'b1, 8'h20, 8'h77);
        set_rq(1, 1'b0, 8'h20, 8'h00);
        #1;
        chk("conf_gnt", gnt, 4'b0001);
        chk("conf_we1", ram_we1, 1);
        chk("conf_we2", ram_we2, 0);
        chk("conf_addr1", ram_addr1, 8'h20);
        @(negedge clk);
        clr();
        set_rq(1, 1'b0, 8'h20, 8'h00);
        #1;
        chk("conf_retry_gnt", gnt, 4'b0010);
        chk("conf_retry_addr1", ram_addr1, 8'h20);
        push(1, 8'h77);
        @(negedge clk);
        // Two writes to different addresses use both ports.
        clr();
        set_rq(2, 1'b1, 8'h50, 8'h11);
        set_rq(3, 1'b1, 8'h51, 8'h22);
        #1;
        chk("ww_gnt", gnt, 4'b1100);
        chk("ww_we2", ram_we2, 1);
        chk("ww_addr2", ram_addr2, 8'h51);
        chk("ww_data2", ram_data2, 8'h22);
        @(negedge clk);
        clr();
        set_rq(0, 1'b0, 8'h51, 8'h00);
        #1;
        chk("rd51_gnt", gnt, 4'b0001);
        push(0, 8'h22);
        @(negedge clk);
        // Two reads of the same address are both granted.
        clr();
        set_rq(0, 1'b0, 8'h50, 8'h00);
        set_rq(1, 1'b0, 8'h50, 8'h00);
        #1;
        chk("rr_same_gnt", gnt, 4'b0011);
        push(0, 8'h11);
        push(1, 8'h11);
        @(negedge clk);
        clr();
        @(negedge clk);

        // Reset asserted in the same cycle as a read request from id3.
        set_rq(3, 1'b0, 8'h33, 8'h00);
        reset = 1'b1;
        #1;
        chk("rst_mid_gnt", gnt, 0);
        @(negedge clk);
        clr();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) set_rq(i, 1'b0, 8'h30 + 8'(i), 8'h00);
        #1;
        chk("rst_ptr0_gnt", gnt, 4'b0011);
        push(0, 8'hCF);
        push(1, 8'hCE);
        @(negedge clk);
        clr();
        repeat (4) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
